// File: rtl/cpu_boot_run_ctrl.sv
// cpu_boot_run_ctrl: boot-and-run controller for the MIPS single-cycle CPU top.
// Streams a word stream into instruction memory, then data memory, while the
// CPU is held in reset; then runs the CPU for RUN_CYCLES cycles and freezes it
// (clock enable low, reset low) so its state can be inspected.
// Optional feature macro: BOOT_CHECKSUM_EN adds the checksum output, a running
// modulo-2^DATA_W sum of every accepted load word.
module cpu_boot_run_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IM_DEPTH   = 64,
  parameter int unsigned DM_DEPTH   = 64,
  parameter int unsigned RUN_CYCLES = 20
) (
  input  logic                        clk_CPU,
  input  logic                        rst_CPU,
  input  logic                        start,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_last,
  output logic                        im_we,
  output logic [$clog2(IM_DEPTH)-1:0] im_addr,
  output logic [DATA_W-1:0]           im_wdata,
  output logic                        dm_we,
  output logic [$clog2(DM_DEPTH)-1:0] dm_addr,
  output logic [DATA_W-1:0]           dm_wdata,
  output logic                        cpu_rst,
  output logic                        cpu_en,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 cycle_count,
  output logic                        err_overflow
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]           checksum
`endif
);

  localparam int unsigned IM_AW = $clog2(IM_DEPTH);
  localparam int unsigned DM_AW = $clog2(DM_DEPTH);
  // Pointers carry one extra bit so they can reach DEPTH (the overflow marker).
  localparam logic [IM_AW:0] IM_LIMIT = (IM_AW+1)'(IM_DEPTH);
  localparam logic [DM_AW:0] DM_LIMIT = (DM_AW+1)'(DM_DEPTH);
  localparam logic [15:0]    RUN_LAST = 16'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IM = 3'd1,
    LOAD_DM = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [IM_AW:0]      r_im_ptr;
  logic [DM_AW:0]      r_dm_ptr;
  logic                r_im_we;
  logic [IM_AW-1:0]    r_im_addr;
  logic [DATA_W-1:0]   r_im_wdata;
  logic                r_dm_we;
  logic [DM_AW-1:0]    r_dm_addr;
  logic [DATA_W-1:0]   r_dm_wdata;
  logic                r_cpu_rst;
  logic                r_cpu_en;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_cycle_count;
  logic                r_err_overflow;

  logic                w_load_ready;
  logic                w_beat;
  logic                w_im_beat;
  logic                w_dm_beat;
  logic                w_im_fit;
  logic                w_dm_fit;
  logic                w_start_load;
  logic                w_cpu_rst;
  logic                w_cpu_en;
  logic                w_busy;
  logic                w_done;

  // Beat qualification, decoded from the registered state.
  always_comb begin
    w_load_ready = (r_state == LOAD_IM) || (r_state == LOAD_DM);
    w_beat       = load_valid && w_load_ready;
    w_im_beat    = w_beat && (r_state == LOAD_IM);
    w_dm_beat    = w_beat && (r_state == LOAD_DM);
    w_im_fit     = (r_im_ptr < IM_LIMIT);
    w_dm_fit     = (r_dm_ptr < DM_LIMIT);
    w_start_load = start && ((r_state == IDLE) || (r_state == DONE));
  end

  // State register.
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD_IM;
      LOAD_IM: if (w_beat && load_last) w_state_next = LOAD_DM;
      LOAD_DM: if (w_beat && load_last) w_state_next = RUN;
      RUN:     if (r_cycle_count == RUN_LAST) w_state_next = DONE;
      DONE:    if (start) w_state_next = LOAD_IM;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the status outputs can be registered
  // and still change on the same edge as the state.
  always_comb begin
    w_cpu_rst = 1'b1;
    w_cpu_en  = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (w_state_next)
      LOAD_IM, LOAD_DM: w_busy = 1'b1;
      RUN: begin
        w_cpu_rst = 1'b0;
        w_cpu_en  = 1'b1;
        w_busy    = 1'b1;
      end
      DONE: begin
        w_cpu_rst = 1'b0;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered CPU control and status outputs.
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      r_cpu_rst <= 1'b1;
      r_cpu_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cpu_rst <= w_cpu_rst;
      r_cpu_en  <= w_cpu_en;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // Load datapath: pointers, one-cycle write strobes, overflow flag, run counter.
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      r_im_ptr       <= '0;
      r_dm_ptr       <= '0;
      r_im_we        <= 1'b0;
      r_im_addr      <= '0;
      r_im_wdata     <= '0;
      r_dm_we        <= 1'b0;
      r_dm_addr      <= '0;
      r_dm_wdata     <= '0;
      r_cycle_count  <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_im_we <= w_im_beat && w_im_fit;
      r_dm_we <= w_dm_beat && w_dm_fit;

      if (w_start_load) begin
        r_im_ptr <= '0;
        r_dm_ptr <= '0;
      end else begin
        if (w_im_beat && w_im_fit) begin
          r_im_addr  <= r_im_ptr[IM_AW-1:0];
          r_im_wdata <= load_data;
          r_im_ptr   <= r_im_ptr + 1'b1;
        end
        if (w_dm_beat && w_dm_fit) begin
          r_dm_addr  <= r_dm_ptr[DM_AW-1:0];
          r_dm_wdata <= load_data;
          r_dm_ptr   <= r_dm_ptr + 1'b1;
        end
      end

      if (w_start_load) begin
        r_err_overflow <= 1'b0;
      end else if ((w_im_beat && !w_im_fit) || (w_dm_beat && !w_dm_fit)) begin
        r_err_overflow <= 1'b1;
      end

      if (w_dm_beat && load_last) begin
        r_cycle_count <= '0;
      end else if (r_state == RUN) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running sum of every accepted word, including dropped overflow words.
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      r_checksum <= '0;
    end else if (w_start_load) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + load_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign load_ready   = w_load_ready;
  assign im_we        = r_im_we;
  assign im_addr      = r_im_addr;
  assign im_wdata     = r_im_wdata;
  assign dm_we        = r_dm_we;
  assign dm_addr      = r_dm_addr;
  assign dm_wdata     = r_dm_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign cpu_en       = r_cpu_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cycle_count  = r_cycle_count;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_cpu_boot_run_ctrl.sv
// Testbench for cpu_boot_run_ctrl: directed load/run sequences with a write
// scoreboard (expected address, data and cycle per memory strobe) and a
// negedge monitor that pops and compares every strobe the DUT issues.
module tb_cpu_boot_run_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned IMD = 4;
  localparam int unsigned DMD = 8;
  localparam int unsigned RC  = 20;

  logic          clk_CPU = 1'b0;
  logic          rst_CPU = 1'b1;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          im_we;
  logic [1:0]    im_addr;
  logic [DW-1:0] im_wdata;
  logic          dm_we;
  logic [2:0]    dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          cpu_rst;
  logic          cpu_en;
  logic          busy;
  logic          done;
  logic [15:0]   cycle_count;
  logic          err_overflow;
`ifdef BOOT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  cpu_boot_run_ctrl #(
    .DATA_W    (DW),
    .IM_DEPTH  (IMD),
    .DM_DEPTH  (DMD),
    .RUN_CYCLES(RC)
  ) dut (
    .clk_CPU     (clk_CPU),
    .rst_CPU     (rst_CPU),
    .start       (start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .cpu_rst     (cpu_rst),
    .cpu_en      (cpu_en),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .err_overflow(err_overflow)
`ifdef BOOT_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk_CPU = ~clk_CPU;

  int cyc = 0;
  always @(posedge clk_CPU) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t q_im[$];
  wr_t q_dm[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write of its memory.
  wr_t mon_im;
  wr_t mon_dm;
  always @(negedge clk_CPU) begin
    if (im_we === 1'b1) begin
      if (q_im.size() == 0) begin
        total++; bad++;
        $display("FAIL im_unexpected: got strobe addr %0d expected none", im_addr);
      end else begin
        mon_im = q_im.pop_front();
        chk("im_addr", 32'(im_addr), 32'(mon_im.addr));
        chk("im_data", im_wdata, mon_im.data);
        chk("im_cycle", 32'(cyc), 32'(mon_im.cyc));
      end
    end
    if (dm_we === 1'b1) begin
      if (q_dm.size() == 0) begin
        total++; bad++;
        $display("FAIL dm_unexpected: got strobe addr %0d expected none", dm_addr);
      end else begin
        mon_dm = q_dm.pop_front();
        chk("dm_addr", 32'(dm_addr), 32'(mon_dm.addr));
        chk("dm_data", dm_wdata, mon_dm.data);
        chk("dm_cycle", 32'(cyc), 32'(mon_dm.cyc));
      end
    end
  end

  // One load beat; a write is expected one cycle after the beat edge.
  task automatic beat(input bit to_dm, input int addr, input logic [31:0] d,
                      input bit last, input bit expect_wr, input bit rst_hit);
    wr_t e;
    @(negedge clk_CPU);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    rst_CPU    = rst_hit;
    chk("load_ready", 32'(load_ready), 32'd1);
    if (expect_wr && !rst_hit) begin
      e.addr = addr; e.data = d; e.cyc = cyc + 1;
      if (to_dm) q_dm.push_back(e); else q_im.push_back(e);
    end
    @(posedge clk_CPU);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    rst_CPU    = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk_CPU);
    start = 1'b1;
    @(negedge clk_CPU);
    start = 1'b0;
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(load_ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err_clear", 32'(err_overflow), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_dm_we"}, 32'(dm_we), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_dm_addr"}, 32'(dm_addr), 32'd0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    chk({tag, "_err"}, 32'(err_overflow), 32'd0);
`ifdef BOOT_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 32'd0);
`endif
  endtask

  // Called right after the last DM beat; counts cpu_en cycles until done.
  task automatic run_check(input bit start_mid);
    int n = 0;
    int guard = 0;
    bit seen_done = 1'b0;
    @(negedge clk_CPU);
    chk("run_en_first", 32'(cpu_en), 32'd1);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    while (!seen_done && guard < 200) begin
      if (cpu_en === 1'b1) n++;
      if (done === 1'b1) seen_done = 1'b1;
      start = start_mid && (n == 5) && !seen_done;
      if (!seen_done) begin
        @(negedge clk_CPU);
        guard++;
      end
    end
    start = 1'b0;
    chk("run_timeout", 32'(seen_done), 32'd1);
    chk("run_en_cycles", 32'(n), 32'(RC));
    chk("done_cpu_en", 32'(cpu_en), 32'd0);
    chk("done_cycle_count", 32'(cycle_count), 32'(RC));
    chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk_CPU);
    #1 rst_CPU = 1'b0;
    @(negedge clk_CPU);
    chk_reset("rst");

    // Basic program: three IM words back to back, one DM word, full run.
    do_start();
    beat(0, 0, 32'h20080005, 0, 1, 0);
    beat(0, 1, 32'h20090003, 0, 1, 0);
    beat(0, 2, 32'h01095020, 1, 1, 0);
    beat(1, 0, 32'h0000000A, 1, 1, 0);
    run_check(0);
    chk("basic_err", 32'(err_overflow), 32'd0);

    // Restart from DONE, load_valid every other cycle, start pulsed mid-run.
    do_start();
    beat(0, 0, 32'h11111111, 0, 1, 0);
    @(posedge clk_CPU);
    beat(0, 1, 32'h22222222, 0, 1, 0);
    @(posedge clk_CPU);
    beat(0, 2, 32'h33333333, 1, 1, 0);
    @(posedge clk_CPU);
    beat(1, 0, 32'h44444444, 0, 1, 0);
    @(posedge clk_CPU);
    beat(1, 1, 32'h55555555, 1, 1, 0);
    run_check(1);

    // IM overflow: six words into a four-word memory.
    do_start();
    beat(0, 0, 32'hA0000000, 0, 1, 0);
    beat(0, 1, 32'hA0000001, 0, 1, 0);
    beat(0, 2, 32'hA0000002, 0, 1, 0);
    beat(0, 3, 32'hA0000003, 0, 1, 0);
    beat(0, 0, 32'hA0000004, 0, 0, 0);
    beat(0, 0, 32'hA0000005, 1, 0, 0);
    chk("ovf_err_set", 32'(err_overflow), 32'd1);
    chk("ovf_ready_dm", 32'(load_ready), 32'd1);
    beat(1, 0, 32'hB0000000, 1, 1, 0);
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);
    run_check(0);
    chk("ovf_err_in_done", 32'(err_overflow), 32'd1);

    // New start clears the flag; reset lands on the second DM beat.
    do_start();
    beat(0, 0, 32'hC0000000, 1, 1, 0);
    beat(1, 0, 32'hC0000001, 0, 1, 0);
    beat(1, 1, 32'hC0000002, 0, 1, 1);
    @(negedge clk_CPU);
    chk_reset("rst_dm");

    // Reset during cycle 7 of RUN.
    do_start();
    beat(0, 0, 32'hD0000000, 1, 1, 0);
    beat(1, 0, 32'hD0000001, 1, 1, 0);
    repeat (6) @(posedge clk_CPU);
    #1;
    chk("run7_count", 32'(cycle_count), 32'd6);
    chk("run7_en", 32'(cpu_en), 32'd1);
    rst_CPU = 1'b1;
    @(posedge clk_CPU);
    #1 rst_CPU = 1'b0;
    @(negedge clk_CPU);
    chk_reset("rst_run");

`ifdef BOOT_CHECKSUM_EN
    // Checksum wrap-around.
    do_start();
    beat(0, 0, 32'hFFFFFFFF, 1, 1, 0);
    chk("csum_first", checksum, 32'hFFFFFFFF);
    beat(1, 0, 32'h00000002, 1, 1, 0);
    chk("csum_wrap", checksum, 32'h00000001);
    run_check(0);
`endif

    @(negedge clk_CPU);
    chk("im_queue_empty", 32'(q_im.size()), 32'd0);
    chk("dm_queue_empty", 32'(q_dm.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
